// File: rtl/mips32_multicycle_sequencer_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the datapath/memory side (slave).
interface mips32_multicycle_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opc;
    logic [5:0]       func;
    logic             aluZero;
    logic             memReady;
    logic             irWrite;
    logic             pcWrite;
    logic [1:0]       pcSrc;
    logic             iorD;
    logic             memRead;
    logic             memWrite;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [2:0]       aluFunc;
    logic             bitXtend;
    logic             rfWriteEnable;
    logic [1:0]       rfWriteDataSel;
    logic             rfWriteAddrSel;
    logic             invOpcode;
    logic             memTimeout;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opc, func, aluZero, memReady,
        output irWrite, pcWrite, pcSrc, iorD, memRead, memWrite, aluSrcA, aluSrcB,
               aluFunc, bitXtend, rfWriteEnable, rfWriteDataSel, rfWriteAddrSel,
               invOpcode, memTimeout, state, retired
    );

    modport slave (
        output opc, func, aluZero, memReady,
        input  irWrite, pcWrite, pcSrc, iorD, memRead, memWrite, aluSrcA, aluSrcB,
               aluFunc, bitXtend, rfWriteEnable, rfWriteDataSel, rfWriteAddrSel,
               invOpcode, memTimeout, state, retired
    );
endinterface

// File: rtl/mips32_multicycle_sequencer.sv
// Multi-cycle MIPS32 control FSM: sequences fetch/decode/execute/memory/writeback over a shared
// memory port, traps on unsupported opcodes or memory stalls, and counts retired instructions.
module mips32_multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input logic                          clk,
    input logic                          rst,
    mips32_multicycle_sequencer_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_EXEC_I = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_ALU = 4'd7;
    localparam logic [3:0] S_WB_MEM = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [3:0]       r_state;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;
    logic             r_inv;
    logic             r_tmo;

    logic [3:0] w_next;
    logic       w_retire;
    logic       w_set_inv;
    logic       w_set_tmo;
    logic       w_waiting;
    logic       w_wait_last;
    logic       w_irWrite, w_pcWrite, w_iorD, w_memRead, w_memWrite, w_aluSrcA;
    logic       w_bitXtend, w_rfWriteEnable, w_rfWriteAddrSel;
    logic [1:0] w_pcSrc, w_aluSrcB, w_rfWriteDataSel;
    logic [2:0] w_aluFunc;

    assign w_waiting   = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_wait_last = (r_wait == WAIT_LAST);

    always_comb begin
        w_next           = r_state;
        w_retire         = 1'b0;
        w_set_inv        = 1'b0;
        w_set_tmo        = 1'b0;
        w_irWrite        = 1'b0;
        w_pcWrite        = 1'b0;
        w_pcSrc          = 2'd0;
        w_iorD           = 1'b0;
        w_memRead        = 1'b0;
        w_memWrite       = 1'b0;
        w_aluSrcA        = 1'b0;
        w_aluSrcB        = 2'd0;
        w_aluFunc        = ALU_ADD;
        w_bitXtend       = 1'b0;
        w_rfWriteEnable  = 1'b0;
        w_rfWriteDataSel = 2'd0;
        w_rfWriteAddrSel = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_aluSrcB = 2'd1;
                // memReady on the limit cycle takes priority over the trap
                if (bus.memReady) begin
                    w_irWrite = 1'b1;
                    w_pcWrite = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_wait_last) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_DECODE: begin
                w_aluSrcB = 2'd3;
                case (bus.opc)
                    OP_RTYPE: begin
                        case (bus.func)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_next = S_EXEC_R;
                            default: begin
                                w_next    = S_HALT;
                                w_set_inv = 1'b1;
                            end
                        endcase
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:                      w_next = S_ADDR;
                    OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
                    OP_J:                              w_next = S_JUMP;
                    default: begin
                        w_next    = S_HALT;
                        w_set_inv = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                w_aluSrcA        = 1'b1;
                w_rfWriteAddrSel = 1'b1;
                case (bus.func)
                    FN_SUB:  w_aluFunc = ALU_SUB;
                    FN_AND:  w_aluFunc = ALU_AND;
                    FN_OR:   w_aluFunc = ALU_OR;
                    FN_SLT:  w_aluFunc = ALU_SLT;
                    default: w_aluFunc = ALU_ADD;
                endcase
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'd2;
                case (bus.opc)
                    OP_SLTI: w_aluFunc = ALU_SLT;
                    OP_ANDI: w_aluFunc = ALU_AND;
                    OP_ORI:  w_aluFunc = ALU_OR;
                    default: w_aluFunc = ALU_ADD;
                endcase
                w_bitXtend = (bus.opc == OP_ANDI) || (bus.opc == OP_ORI);
                w_next     = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_rfWriteEnable  = 1'b1;
                w_rfWriteAddrSel = (bus.opc == OP_RTYPE);
                w_retire         = 1'b1;
                w_next           = S_FETCH;
            end
            S_ADDR: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'd2;
                w_next    = (bus.opc == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
                if (bus.memReady) begin
                    w_next = S_WB_MEM;
                end else if (w_wait_last) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_WB_MEM: begin
                w_rfWriteEnable  = 1'b1;
                w_rfWriteDataSel = 2'd1;
                w_retire         = 1'b1;
                w_next           = S_FETCH;
            end
            S_MEM_WR: begin
                w_memWrite = 1'b1;
                w_iorD     = 1'b1;
                if (bus.memReady) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_wait_last) begin
                    w_set_tmo = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_BRANCH: begin
                w_aluSrcA = 1'b1;
                w_aluFunc = ALU_SUB;
                w_pcSrc   = 2'd1;
                w_pcWrite = ((bus.opc == OP_BEQ) && bus.aluZero) ||
                            ((bus.opc == OP_BNE) && !bus.aluZero);
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                w_pcWrite = 1'b1;
                w_pcSrc   = 2'd2;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_inv     <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_state <= w_next;
            // every wait state is entered from a different state, so a transition clears the counter
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (w_waiting && !bus.memReady) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_set_inv) begin
                r_inv <= 1'b1;
            end
            if (w_set_tmo) begin
                r_tmo <= 1'b1;
            end
        end
    end

    assign bus.irWrite        = w_irWrite;
    assign bus.pcWrite        = w_pcWrite;
    assign bus.pcSrc          = w_pcSrc;
    assign bus.iorD           = w_iorD;
    assign bus.memRead        = w_memRead;
    assign bus.memWrite       = w_memWrite;
    assign bus.aluSrcA        = w_aluSrcA;
    assign bus.aluSrcB        = w_aluSrcB;
    assign bus.aluFunc        = w_aluFunc;
    assign bus.bitXtend       = w_bitXtend;
    assign bus.rfWriteEnable  = w_rfWriteEnable;
    assign bus.rfWriteDataSel = w_rfWriteDataSel;
    assign bus.rfWriteAddrSel = w_rfWriteAddrSel;
    assign bus.invOpcode      = r_inv;
    assign bus.memTimeout     = r_tmo;
    assign bus.state          = r_state;
    assign bus.retired        = r_retired;
endmodule
